// File: rtl/shift_pkg.sv
// Shared types and the effective-shift-amount helper for the sequential shifter.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_LSL  = 3'd0,
        MODE_ASL  = 3'd1,
        MODE_LSR  = 3'd2,
        MODE_ASR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_RSV6 = 3'd6,
        MODE_RSV7 = 3'd7
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

    // Shifts saturate at the word width; rotates wrap (w is a power of two).
    function automatic int unsigned eff_amt(input int unsigned amt,
                                            input shift_mode_e mode,
                                            input int unsigned w);
        int unsigned n;
        n = 0;
        case (mode)
            MODE_LSL, MODE_ASL, MODE_LSR, MODE_ASR: n = (amt > w) ? w : amt;
            MODE_ROL, MODE_ROR:                     n = amt % w;
            default:                                n = 0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step; the engine registers its outputs once per clock.
module shift_step
    import shift_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    input  shift_mode_e  mode,
    output logic [W-1:0] next_data,
    output logic         bit_out,
    output logic         msb_changed
);

    always_comb begin
        next_data = data;
        bit_out   = 1'b0;
        case (mode)
            MODE_LSL, MODE_ASL: begin
                next_data = {data[W-2:0], 1'b0};
                bit_out   = data[W-1];
            end
            MODE_LSR: begin
                next_data = {1'b0, data[W-1:1]};
                bit_out   = data[0];
            end
            MODE_ASR: begin
                next_data = {data[W-1], data[W-1:1]};
                bit_out   = data[0];
            end
            MODE_ROL: begin
                next_data = {data[W-2:0], data[W-1]};
                bit_out   = data[W-1];
            end
            MODE_ROR: begin
                next_data = {data[0], data[W-1:1]};
                bit_out   = data[0];
            end
            default: begin
                next_data = data;
                bit_out   = 1'b0;
            end
        endcase
    end

    assign msb_changed = next_data[W-1] ^ data[W-1];

endmodule

// File: rtl/shift_seq_engine.sv
// Multi-cycle programmable shifter: one bit per clock, valid/ready in and out.
module shift_seq_engine
    import shift_pkg::*;
#(
    parameter int W     = 8,
    parameter int AMT_W = $clog2(W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             busy
);

    shift_state_e     state_reg, state_next;
    logic [W-1:0]     data_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic [AMT_W-1:0] count_reg;
    shift_mode_e      mode_reg;

    logic [AMT_W-1:0] amt_eff;
    logic             accept;
    logic [W-1:0]     step_data;
    logic             step_bit;
    logic             step_msb;

    assign amt_eff = AMT_W'(eff_amt(32'(in_amt), shift_mode_e'(in_mode), 32'(W)));
    assign accept  = in_valid & in_ready;

    shift_step #(.W(W)) u_step (
        .data        (data_reg),
        .mode        (mode_reg),
        .next_data   (step_data),
        .bit_out     (step_bit),
        .msb_changed (step_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = (amt_eff != '0) ? SHIFT : DONE;
            SHIFT:   if (count_reg == AMT_W'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only, so no comb path from in_valid/out_ready.
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
        busy      = (state_reg == SHIFT) || (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            count_reg <= '0;
            mode_reg  <= MODE_LSL;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        data_reg  <= in_data;
                        mode_reg  <= shift_mode_e'(in_mode);
                        count_reg <= amt_eff;
                        carry_reg <= 1'b0;
                        ovf_reg   <= 1'b0;
                    end
                end
                SHIFT: begin
                    data_reg  <= step_data;
                    carry_reg <= step_bit;
                    if (mode_reg == MODE_ASL) ovf_reg <= ovf_reg | step_msb;
                    count_reg <= count_reg - AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_data  = data_reg;
    assign out_carry = carry_reg;
    assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_shift_seq_engine.sv
// Directed and random checks of shift_seq_engine against an arithmetic reference model.
module tb_shift_seq_engine;

    localparam int W     = 8;
    localparam int AMT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [AMT_W-1:0] in_amt;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_carry;
    logic             out_ovf;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        logic         ovf;
        int           n;
    } model_t;

    shift_seq_engine #(.W(W), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whole-operation result computed in one go from the mode rules.
    function automatic model_t model(input logic [W-1:0] d, input int amt, input int mode);
        model_t m;
        int n;
        logic signed [W-1:0] sres;
        case (mode)
            0, 1, 2, 3: n = (amt > W) ? W : amt;
            4, 5:       n = amt % W;
            default:    n = 0;
        endcase
        m.n = n; m.data = d; m.carry = 1'b0; m.ovf = 1'b0;
        if (n > 0) begin
            case (mode)
                0, 1: begin
                    m.data  = W'((int'(d) << n) & ((1 << W) - 1));
                    m.carry = d[W-n];
                    if (mode == 1) begin
                        sres  = $signed(m.data) >>> n;
                        m.ovf = (sres != $signed(d));
                    end
                end
                2: begin m.data = d >> n; m.carry = d[n-1]; end
                3: begin m.data = W'($signed(d) >>> n); m.carry = d[n-1]; end
                4: begin m.data = (d << n) | (d >> (W - n)); m.carry = m.data[0]; end
                5: begin m.data = (d >> n) | (d << (W - n)); m.carry = m.data[W-1]; end
                default: ;
            endcase
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] d, input int amt, input int mode, input int hold);
        model_t m;
        int lat;
        m = model(d, amt, mode);
        @(negedge clk);
        in_data = d; in_amt = AMT_W'(amt); in_mode = 3'(mode); in_valid = 1'b1; out_ready = 1'b0;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_amt   = AMT_W'($urandom);
        in_mode  = 3'($urandom);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        $display("op mode=%0d d=%02h amt=%0d -> data=%02h carry=%0d ovf=%0d lat=%0d (exp %02h %0d %0d lat %0d)",
                 mode, d, amt, out_data, out_carry, out_ovf, lat, m.data, m.carry, m.ovf, m.n);
        check("latency", 32'(lat), 32'(m.n));
        check("out_data", 32'(out_data), 32'(m.data));
        check("out_carry", 32'(out_carry), 32'(m.carry));
        check("out_ovf", 32'(out_ovf), 32'(m.ovf));
        check("busy_done", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(m.data));
            check("hold_carry", 32'(out_carry), 32'(m.carry));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_one_cycle", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        run_op(8'h17, 3, 1, 0);
        run_op(8'h96, 2, 3, 0);
        run_op(8'h81, 9, 4, 0);
        run_op(8'h01, 1, 5, 0);
        run_op(8'hFF, 12, 2, 0);
        run_op(8'hA5, 5, 6, 0);
        run_op(8'h5A, 0, 0, 5);
        run_op(8'h40, 1, 1, 0);

        // Reset during SHIFT must abort the operation without a result.
        @(negedge clk);
        in_data = 8'hF0; in_amt = 4'd6; in_mode = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        check("abort_carry", 32'(out_carry), 32'd0);
        check("abort_ovf", 32'(out_ovf), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(8'h80, 7, 3, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
